// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around a pipelined N-point FFT core: assembles a serial frame,
// launches it as one parallel word, waits out the core latency, then drains the result serially.
module fft_frame_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int N_POINT      = 16,
  parameter int CORE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] core_x [N_POINT],
  input  logic [DATA_WIDTH-1:0] core_y [N_POINT],
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam int IDX_W = (N_POINT > 1) ? $clog2(N_POINT) : 1;
  localparam int CNT_W = $clog2(CORE_LATENCY + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINT - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(CORE_LATENCY);

  typedef enum logic {
    FILL,
    FULL
  } in_state_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [DATA_WIDTH-1:0] in_buf  [N_POINT];
  logic [DATA_WIDTH-1:0] out_buf [N_POINT];
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [CNT_W-1:0]      lat_cnt;

  logic s_fire;
  logic m_fire;
  logic launch;
  logic capture;

  always_comb begin
    launch  = (in_state == FULL) && (out_state == IDLE);
    capture = (out_state == WAIT) && (lat_cnt == '0);
    s_fire  = s_valid && s_ready;
    m_fire  = m_valid && m_ready;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_state  <= FILL;
      out_state <= IDLE;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
    end
  end

  // Next-state logic
  always_comb begin
    in_next = in_state;
    unique case (in_state)
      FILL: if (s_fire && (wr_idx == LAST_IDX)) in_next = FULL;
      FULL: if (launch) in_next = FILL;
    endcase
  end

  always_comb begin
    out_next = out_state;
    unique case (out_state)
      IDLE:    if (launch) out_next = WAIT;
      WAIT:    if (capture) out_next = DRAIN;
      DRAIN:   if (m_fire && (rd_idx == LAST_IDX)) out_next = IDLE;
      default: out_next = IDLE;
    endcase
  end

  // Outputs; s_ready is gated by rst_n so it reads 0 throughout reset
  always_comb begin
    s_ready = rst_n && (in_state == FILL);
    m_valid = (out_state == DRAIN);
    m_data  = m_valid ? out_buf[rd_idx] : '0;
    m_last  = m_valid && (rd_idx == LAST_IDX);
    busy    = (out_state != IDLE);
  end

  // Index counters, latency counter and the launch register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      lat_cnt <= '0;
      for (int unsigned i = 0; i < N_POINT; i++) core_x[i] <= '0;
    end else begin
      if (launch) begin
        wr_idx <= '0;
      end else if (s_fire) begin
        wr_idx <= wr_idx + IDX_W'(1);
      end

      if (launch) begin
        lat_cnt <= LAT_LOAD;
        for (int unsigned i = 0; i < N_POINT; i++) core_x[i] <= in_buf[i];
      end else if ((out_state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end

      if (capture) begin
        rd_idx <= '0;
      end else if (m_fire) begin
        rd_idx <= rd_idx + IDX_W'(1);
      end
    end
  end

  // Sample buffers carry no reset: every word is rewritten before it is used
  always_ff @(posedge clk) begin
    if (s_fire) in_buf[wr_idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < N_POINT; i++) out_buf[i] <= core_y[i];
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with stub cores computing y = x + 1 through
// CORE_LATENCY registered stages; covers the 16/4 default and an 8/3 build.
module tb_fft_frame_ctrl;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [DW-1:0] s_data, m_data;
  logic          s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [DW-1:0] core_x [16];
  logic [DW-1:0] core_y [16];
  logic [DW-1:0] pipe16 [4][16];

  logic [DW-1:0] s_data8, m_data8;
  logic          s_valid8, s_ready8, m_valid8, m_ready8, m_last8, busy8;
  logic [DW-1:0] core_x8 [8];
  logic [DW-1:0] core_y8 [8];
  logic [DW-1:0] pipe8 [3][8];

  fft_frame_ctrl #(.DATA_WIDTH(DW), .N_POINT(16), .CORE_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_x(core_x), .core_y(core_y),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy)
  );

  fft_frame_ctrl #(.DATA_WIDTH(DW), .N_POINT(8), .CORE_LATENCY(3)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
    .core_x(core_x8), .core_y(core_y8),
    .m_data(m_data8), .m_valid(m_valid8), .m_ready(m_ready8), .m_last(m_last8),
    .busy(busy8)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      pipe16[0][i] <= core_x[i] + 16'd1;
      for (int s = 1; s < 4; s++) pipe16[s][i] <= pipe16[s-1][i];
    end
    for (int i = 0; i < 8; i++) begin
      pipe8[0][i] <= core_x8[i] + 16'd1;
      for (int s = 1; s < 3; s++) pipe8[s][i] <= pipe8[s-1][i];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) core_y[i] = pipe16[3][i];
    for (int i = 0; i < 8; i++) core_y8[i] = pipe8[2][i];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic          e_ml;
    logic          e_busy;
    logic [DW-1:0] e_cx;
  } vec_t;

  vec_t tbl16 [40];
  vec_t tbl8  [28];

  // One clean frame from idle: samples base..base+n-1 in cycles 0..n-1, m_ready held high.
  // Last accept edge a = n, launch a+1, first valid cycle a+lat+2, e_cx is core_x[n-1].
  function automatic vec_t mk(int k, int n, int lat, int base);
    vec_t v;
    int fv, lv;
    fv       = n + lat + 2;
    lv       = fv + n - 1;
    v.sv     = (k < n);
    v.sd     = (k < n) ? 16'(base + k) : 16'd0;
    v.mr     = 1'b1;
    v.e_sr   = (k != n);
    v.e_mv   = (k >= fv) && (k <= lv);
    v.e_md   = v.e_mv ? 16'(base + k - fv + 1) : 16'd0;
    v.e_ml   = (k == lv);
    v.e_busy = (k > n) && (k <= lv);
    v.e_cx   = (k > n) ? 16'(base + n - 1) : 16'd0;
    return v;
  endfunction

  logic [DW-1:0] expq [$];
  int n_in, n_out;

  task automatic sample();
    @(negedge clk);
    if (s_valid && s_ready) begin
      expq.push_back(s_data + 16'd1);
      n_in++;
    end
    if (m_valid && m_ready) begin
      if (expq.size() == 0) begin
        check("sb_underflow", 32'(expq.size()), 32'd1);
      end else begin
        check("sb_m_data", m_data, expq.pop_front());
        check("sb_m_last", m_last, (n_out % 16) == 15);
      end
      n_out++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int base, input int nsamp, input int gap, input int nout, input int budget);
    int cyc;
    cyc = 0;
    while ((n_in < nsamp || n_out < nout) && cyc < budget) begin
      s_valid = (n_in < nsamp) && ($urandom_range(0, 99) >= gap);
      s_data  = 16'(base + n_in);
      sample();
      advance();
      cyc++;
    end
    s_valid = 1'b0;
    check($sformatf("run_done base=%0d", base), (n_in >= nsamp) && (n_out >= nout), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got t=%0t expected summary first", $time);
    $fatal(1);
  end

  initial begin
    logic          found, prev_rdy, prev_last;
    logic [DW-1:0] prev_data;
    int            n0;

    for (int k = 0; k < 40; k++) tbl16[k] = mk(k, 16, 4, 0);
    for (int k = 0; k < 28; k++) tbl8[k] = mk(k, 8, 3, 'h40);

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    s_valid8 = 1'b0; s_data8 = '0; m_ready8 = 1'b1;
    n_in = 0; n_out = 0;
    repeat (3) advance();

    @(negedge clk);
    check("rst s_ready", s_ready, 1'b0);
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_data", m_data, 16'd0);
    check("rst m_last", m_last, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst s_ready8", s_ready8, 1'b0);
    check("rst m_valid8", m_valid8, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("rst core_x[%0d]", i), core_x[i], 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single frame, cycle-exact
    for (int k = 0; k < 40; k++) begin
      s_valid = tbl16[k].sv; s_data = tbl16[k].sd; m_ready = tbl16[k].mr;
      @(negedge clk);
      check($sformatf("t16[%0d] s_ready", k), s_ready, tbl16[k].e_sr);
      check($sformatf("t16[%0d] m_valid", k), m_valid, tbl16[k].e_mv);
      check($sformatf("t16[%0d] m_last", k), m_last, tbl16[k].e_ml);
      check($sformatf("t16[%0d] busy", k), busy, tbl16[k].e_busy);
      check($sformatf("t16[%0d] core_x15", k), core_x[15], tbl16[k].e_cx);
      if (tbl16[k].e_mv) check($sformatf("t16[%0d] m_data", k), m_data, tbl16[k].e_md);
      advance();
    end
    s_valid = 1'b0;

    // Back-pressure: m_ready alternates 1/0 once the frame is presented
    n_in = 0; n_out = 0; expq.delete();
    m_ready = 1'b0;
    run(100, 16, 0, 0, 40);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (m_valid) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    check("bp first m_valid seen", found, 1'b1);
    prev_data = m_data; prev_last = m_last; prev_rdy = 1'b0;
    advance();
    n0 = n_out;
    for (int i = 0; i < 31; i++) begin
      m_ready = (i % 2 == 0);
      sample();
      check($sformatf("bp[%0d] m_valid", i), m_valid, 1'b1);
      if (!prev_rdy) begin
        check($sformatf("bp[%0d] hold m_data", i), m_data, prev_data);
        check($sformatf("bp[%0d] hold m_last", i), m_last, prev_last);
      end
      prev_data = m_data; prev_last = m_last; prev_rdy = m_ready;
      advance();
    end
    check("bp transfers in 31 cycles", n_out - n0, 16);
    m_ready = 1'b1;
    sample();
    check("bp drained m_valid", m_valid, 1'b0);
    check("bp drained busy", busy, 1'b0);
    advance();

    // Three back-to-back frames; launch of frame 2 expected at the end of cycle 38
    n_in = 0; n_out = 0; expq.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 90; c++) begin
      s_valid = (n_in < 48);
      s_data  = 16'(500 + n_in);
      sample();
      case (c)
        16: check("ov c16 s_ready", s_ready, 1'b0);
        32: check("ov c32 s_ready", s_ready, 1'b1);
        33: check("ov c33 s_ready", s_ready, 1'b0);
        37: check("ov c37 m_last", m_last, 1'b1);
        38: begin
          check("ov c38 s_ready", s_ready, 1'b0);
          check("ov c38 busy", busy, 1'b0);
        end
        39: begin
          check("ov c39 s_ready", s_ready, 1'b1);
          check("ov c39 busy", busy, 1'b1);
        end
        60: begin
          check("ov c60 s_ready", s_ready, 1'b0);
          check("ov c60 busy", busy, 1'b0);
        end
        61: check("ov c61 busy", busy, 1'b1);
        default: ;
      endcase
      advance();
    end
    s_valid = 1'b0;
    check("ov inputs", n_in, 48);
    check("ov outputs", n_out, 48);
    check("ov leftover", 32'(expq.size()), 32'd0);

    // Random input gaps
    n_in = 0; n_out = 0; expq.delete();
    run(200, 16, 50, 16, 200);
    check("gap leftover", 32'(expq.size()), 32'd0);

    // Reset during DRAIN at rd_idx 5 with 8 samples of the next frame buffered
    n_in = 0; n_out = 0; expq.delete();
    run(300, 24, 0, 5, 80);
    rst_n = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
    sample();
    check("mid-rst s_ready low", s_ready, 1'b0);
    advance();
    sample();
    check("mid-rst m_valid", m_valid, 1'b0);
    check("mid-rst busy", busy, 1'b0);
    check("mid-rst m_last", m_last, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("mid-rst core_x[%0d]", i), core_x[i], 16'd0);
    advance();
    rst_n = 1'b1;
    n_in = 0; n_out = 0; expq.delete();
    m_ready = 1'b1;
    run(400, 16, 0, 16, 60);
    check("post-rst leftover", 32'(expq.size()), 32'd0);

    // N_POINT=8, CORE_LATENCY=3 build, cycle-exact
    for (int k = 0; k < 28; k++) begin
      s_valid8 = tbl8[k].sv; s_data8 = tbl8[k].sd; m_ready8 = tbl8[k].mr;
      @(negedge clk);
      check($sformatf("t8[%0d] s_ready", k), s_ready8, tbl8[k].e_sr);
      check($sformatf("t8[%0d] m_valid", k), m_valid8, tbl8[k].e_mv);
      check($sformatf("t8[%0d] m_last", k), m_last8, tbl8[k].e_ml);
      check($sformatf("t8[%0d] busy", k), busy8, tbl8[k].e_busy);
      check($sformatf("t8[%0d] core_x7", k), core_x8[7], tbl8[k].e_cx);
      if (tbl8[k].e_mv) check($sformatf("t8[%0d] m_data", k), m_data8, tbl8[k].e_md);
      advance();
    end
    s_valid8 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer in front of and behind the 4-stage pipelined `fft_N_point_core`. It collects a serial sample stream into an N-point frame and launches the frame into the core as one parallel word. It then waits out the core pipeline latency, captures the parallel result and streams it out serially with valid/ready. One frame is in the core at a time, and the next input frame fills while the current result drains.

## Interface
- `DATA_WIDTH`, 16, sample width; matches the core.
- `N_POINT`, 16, samples per frame; power of two, ≥2.
- `CORE_LATENCY`, 4, clock edges from a `core_x` update to the matching `core_y` update (one per core stage).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_data`  in  DATA_WIDTH  input sample.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  controller accepts a sample.
- `core_x`  out  DATA_WIDTH × N_POINT (unpacked)  frame driven to the core `x`.
- `core_y`  in  DATA_WIDTH × N_POINT (unpacked)  core result `y`.
- `m_data`  out  DATA_WIDTH  output sample.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream accepts.
- `m_last`  out  1  marks output index N_POINT-1.
- `busy`  out  1  a frame is in WAIT or DRAIN.

## Operation
- Input FSM has two states, FILL and FULL.
  - FILL: `s_ready`=1. On `s_valid&s_ready`, write `in_buf[wr_idx]` and increment `wr_idx`. On the accept at `wr_idx`=N_POINT-1, go to FULL.
  - FULL: `s_ready`=0. Hold until launch.
- Output FSM has three states, IDLE, WAIT and DRAIN.
  - IDLE: waiting for a frame.
  - WAIT: a down-counter is loaded with CORE_LATENCY at launch. At the edge where the counter is 0, `out_buf <= core_y`, `rd_idx`=0, and the FSM goes to DRAIN. WAIT therefore lasts CORE_LATENCY+1 cycles.
  - DRAIN: `m_valid`=1, `m_data`=`out_buf[rd_idx]`, `m_last`=(`rd_idx`==N_POINT-1). Each `m_valid&m_ready` increments `rd_idx`. The transfer with `m_last` returns the FSM to IDLE.
- Launch occurs in a cycle where input is FULL and output is IDLE. On that edge:
  - `core_x <= in_buf` (all N_POINT words at once).
  - Input goes to FILL with `wr_idx`=0.
  - Output goes to WAIT.
- `core_x` holds its value between launches. The core recomputes on the held value, which is harmless.
- Launch is never simultaneous with the final DRAIN transfer, because output must already be IDLE. Worst-case launch is the cycle after the `m_last` transfer.
- No data loss is possible: the input side is back-pressured through `s_ready` and the output side through `m_ready`.
- Samples pass through unmodified. The controller does no arithmetic; index counters are clog2(N_POINT) bits wide.
- `busy` = (output state ≠ IDLE).

## Timing
- Reset (`rst_n`=0 at an edge) forces input to FILL with `wr_idx`=0 and output to IDLE with counters 0.
- Reset values of all outputs: `s_ready`=0 while `rst_n`=0, and 1 in the first cycle after release. `core_x`, `m_data`, `m_valid`, `m_last` and `busy` are all 0.
- Reset mid-frame discards partial input, in-flight and draining data. No `m_valid` appears until a new full frame completes.
- Latency: Nth input accepted at edge a → launch at edge a+1 → capture at edge a+CORE_LATENCY+2 → `m_valid` high in the following cycle. This is edge a+6 for default parameters.
- Throughput with `m_ready`=1: one frame per max(N_POINT+1, CORE_LATENCY+2+N_POINT) cycles. For defaults that is 22 cycles.
- `m_valid` stays high and `m_data`/`m_last` stay stable while `m_ready`=0.
- `s_valid` with `s_ready`=0 is ignored. The sample is not consumed.

## Test plan
- Single frame: after reset, feed samples 0..15 back-to-back, with a stub core where `y` = `x`+1 after 4 registered stages. Required: `core_x` changes at edge a+1; the first `m_valid` cycle begins at edge a+6; outputs are 1..16; `m_last` is set only on 16; `busy` falls after the last transfer.
- Back-pressure: toggle `m_ready` 1/0 every cycle. Required: each value is held until accepted; exactly 16 transfers occur in 31 cycles; order is preserved.
- Overlap: stream 3 frames continuously with `m_ready`=1. Required: `s_ready` drops after the 16th sample of frame 2 until frame 1 drains; the next launch occurs the cycle after frame 1's `m_last` transfer; all 48 outputs are correct and in order.
- Input gaps: `s_valid` random at 50%. Required: the frame is assembled in arrival order and the output matches the gap-free run.
- Reset mid-operation: assert `rst_n`=0 during DRAIN at `rd_idx`=5 while input is half full. Required: next cycle `m_valid`=0, `busy`=0, `core_x`=0; a fresh frame then produces correct output with no stale samples.
- Parameters: N_POINT=8, CORE_LATENCY=3. Required: `m_last` is set on the 8th output; first `m_valid` occurs at edge a+5.
